// File: rtl/adder_4bit_serial_ctrl.sv
// rtl/adder_4bit_serial_ctrl.sv - nibble-serial wide adder controller around an external adder_4bit
module adder_4bit_serial_ctrl #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES,
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   // upstream operand handshake
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   // adder_4bit side
   output logic [3:0]   o_add_a,
   output logic [3:0]   o_add_b,
   output logic         o_add_cin,
   input  logic [3:0]   i_add_sum,
   input  logic         i_add_cout,
   // downstream result handshake
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic         o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic              cin_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx_q;
   logic [W-1:0]      sum_q;
   logic              cout_q;

   logic              last_nibble;
   logic [IDXW+1:0]   bit_base;

   // Bit offset of the nibble currently being fed to the adder.
   assign bit_base    = {idx_q, 2'b00};
   assign last_nibble = (idx_q == IDXW'(NIBBLES - 1));

   assign o_sum  = sum_q;
   assign o_cout = cout_q;

   // State register; reset always returns to IDLE and drops any pending result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/adder-port decode.
   always_comb begin
      state_d   = state_q;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      o_busy    = 1'b0;
      o_add_a   = 4'd0;
      o_add_b   = 4'd0;
      o_add_cin = 1'b0;
      case (state_q)
         IDLE: begin
            // o_ready is suppressed during reset so no operand is taken.
            o_ready = ~i_rst;
            if (i_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            o_busy    = 1'b1;
            // Adder inputs come only from registers: no path from i_add_* here.
            o_add_a   = a_q[bit_base +: 4];
            o_add_b   = b_q[bit_base +: 4];
            o_add_cin = (idx_q == '0) ? cin_q : carry_q;
            if (last_nibble) begin
               state_d = DONE;
            end
         end
         DONE: begin
            o_busy  = 1'b1;
            // Result is withdrawn while reset is asserted so no transfer happens.
            o_valid = ~i_rst;
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture, nibble-by-nibble sum collection and carry chaining.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  a_q   <= i_a;
                  b_q   <= i_b;
                  cin_q <= i_cin;
                  idx_q <= '0;
               end
            end
            RUN: begin
               sum_q[bit_base +: 4] <= i_add_sum;
               carry_q              <= i_add_cout;
               if (last_nibble) begin
                  cout_q <= i_add_cout;
                  idx_q  <= '0;
               end else begin
                  idx_q  <= idx_q + 1'b1;
               end
            end
            default: begin
               // DONE holds the result untouched until the next operation.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_4bit_serial_ctrl.sv
// tb/tb_adder_4bit_serial_ctrl.sv - self-checking bench for adder_4bit_serial_ctrl with an adder in the loop
module tb_adder_4bit_serial_ctrl;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic [3:0]    add_a;
   logic [3:0]    add_b;
   logic          add_cin;
   logic [3:0]    add_sum;
   logic          add_cout;
   logic          out_valid;
   logic          in_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // 4-bit ripple adder behaviour closing the loop around the controller.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   adder_4bit_serial_ctrl #(.NIBBLES(NIB)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_valid    (in_valid),
      .o_ready    (out_ready),
      .i_a        (a),
      .i_b        (b),
      .i_cin      (cin),
      .o_add_a    (add_a),
      .o_add_b    (add_b),
      .o_add_cin  (add_cin),
      .i_add_sum  (add_sum),
      .i_add_cout (add_cout),
      .o_valid    (out_valid),
      .i_ready    (in_ready),
      .o_sum      (sum),
      .o_cout     (cout),
      .o_busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Hand one operation in, wait for the result, check it, then consume it.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input string tag);
      int n;
      logic [W:0] exp;
      exp = ref_add(x, y, c);
      n = 0;
      while (!out_ready && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, out_ready, 1);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = c;
      tick();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, NIB);
      check({tag, "_result"}, {cout, sum}, exp);
      check({tag, "_busy_done"}, busy, 1);
      check({tag, "_ready_done"}, out_ready, 0);
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check({tag, "_valid_clear"}, out_valid, 0);
      check({tag, "_busy_idle"}, busy, 0);
   endtask

   initial begin : stim
      int n;
      int e0;
      int gap;
      bit stop;
      bit rdy;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   rexp;
      logic [W-1:0] held;

      rst = 1'b1;
      in_valid = 1'b0;
      in_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      tick();
      tick();

      // Reset state; o_ready must stay low while reset is held.
      check("rst_ready", out_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_busy", busy, 0);
      check("rst_add", {add_a, add_b, add_cin}, 0);

      // Reset wins over an upstream handshake.
      in_valid = 1'b1;
      a = 16'h1111;
      tick();
      check("rst_no_accept", busy, 0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("idle_ready", out_ready, 1);

      run_op(16'h1234, 16'h4321, 1'b0, "t1");
      run_op(16'hFFFF, 16'h0001, 1'b0, "t2");
      run_op(16'hFFFF, 16'h0000, 1'b1, "t3a");
      run_op(16'h0000, 16'h0000, 1'b0, "t3b");

      // Backpressure in DONE with a new operand pulsed meanwhile.
      in_valid = 1'b1;
      a = 16'hA5A5;
      b = 16'h5A5A;
      cin = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("bp_latency", n, NIB);
      held = sum;
      check("bp_result", {cout, sum}, ref_add(16'hA5A5, 16'h5A5A, 1'b1));
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         a = 16'h0102;
         b = 16'h0304;
         cin = 1'b0;
         tick();
         check("bp_valid", out_valid, 1);
         check("bp_sum", sum, held);
         check("bp_ready", out_ready, 0);
      end
      in_valid = 1'b1;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check("bp_back_idle", {busy, out_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check("bp_second_accept", busy, 1);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("bp_second_result", {cout, sum}, ref_add(16'h0102, 16'h0304, 1'b0));
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;

      // Reset on the second RUN cycle discards the operation.
      in_valid = 1'b1;
      a = 16'h7777;
      b = 16'h8888;
      cin = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", out_ready, 0);
      check("mid_rst_sum", sum, 0);
      rst = 1'b0;
      #1;
      check("mid_rst_ready_after", out_ready, 1);
      in_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("mid_rst_no_stale", out_valid, 0);
      end
      in_ready = 1'b0;

      // Random operands with random gaps on both handshakes.
      stop = 1'b0;
      for (int k = 0; k < 200 && !stop; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         rexp = ref_add(ra, rb, rc);
         e0 = errors;
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
         in_valid = 1'b1;
         a = ra;
         b = rb;
         cin = rc;
         tick();
         in_valid = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
         n = 0;
         while (!out_valid && n < 50) begin
            tick();
            n++;
         end
         check("rand_latency", n, NIB);
         check("rand_result", {cout, sum}, rexp);
         n = 0;
         do begin
            rdy = 1'($urandom_range(0, 1));
            in_ready = rdy;
            tick();
            if (!rdy) begin
               check("rand_hold", {out_valid, cout, sum}, {1'b1, rexp});
            end
            n++;
         end while (!rdy && n < 20);
         in_ready = 1'b1;
         if (!rdy) tick();
         in_ready = 1'b0;
         check("rand_consumed", out_valid, 0);
         if (errors != e0) begin
            $display("FAIL rand op %0d a=0x%0h b=0x%0h cin=%0d", k, ra, rb, rc);
            stop = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
